countdown_reg: RTL and testbench
================================

Name: countdown_reg

Overview:
- Loadable down-counter register with a start/done handshake.
- Counts a programmed value down to zero, then raises `done` and holds it until the consumer acknowledges.
- Counterpart to the free-running up-counter register: it consumes a count instead of producing one.
- Used as a cycle timer by control FSMs in the register datapath.

Parameters:
- WIDTH, 4, bit width of the loaded value and the counter register.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the clk rising edge.
- load  input  1  capture load_value into the counter (IDLE only).
- load_value  input  WIDTH  value to count down from.
- start  input  1  begin counting (IDLE only).
- pause  input  1  freeze the count while RUN/HOLD.
- stop  input  1  abort the count, return to IDLE.
- ack  input  1  consumer acknowledges done.
- cd_data_output  output  WIDTH  current counter value (registered).
- busy  output  1  high in RUN or HOLD.
- done  output  1  high in DONE.
- state_out  output  2  current FSM state encoding.

Behaviour:
- Reset (synchronous, active-high):
  - cd_data_output=0, state=IDLE, busy=0, done=0, shadow register=0.
  - Reset has priority over every other input in every state, including mid-count.
- State encoding: IDLE=2'b00, RUN=2'b01, HOLD=2'b10, DONE=2'b11.
- busy and done are decoded from registered state; no combinational path from inputs.
- IDLE:
  - load=1: cd_data_output<=load_value and shadow<=load_value; start is ignored in the same cycle (load wins).
  - start=1, load=0, value!=0: go to RUN; no decrement on that edge.
  - start=1, load=0, value==0: go straight to DONE.
  - stop, pause, ack: no effect.
- RUN, priority stop > pause > decrement:
  - stop: go to IDLE, value retained.
  - pause: go to HOLD, value unchanged.
  - otherwise: cd_data_output<=cd_data_output-1.
  - The edge that writes 0 also moves to DONE.
  - load and start are ignored.
- Latency: start sampled at edge N gives the first decrement at edge N+1. For a loaded value V≥1, done is first high after edge N+V, with cd_data_output=0.
- HOLD:
  - stop: go to IDLE.
  - pause=0: go to RUN; decrementing resumes on the following edge.
  - Value held throughout.
- DONE:
  - done=1 and cd_data_output=0.
  - ack=1: go to IDLE.
  - All other inputs ignored.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - Underflow cannot occur: RUN is never entered at 0, and decrement stops at 0.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined: the RUN edge that would write 0 instead writes the shadow value and stays in RUN.
  - done pulses high for exactly that one cycle; the state machine does not enter DONE.
  - ack is ignored.
  - pause and stop behave as above.
  - The period is V cycles per reload.
  - Shadow value 0: start still goes to DONE, same as without the macro.
- Undefined: behaviour exactly as in the Behaviour section; no shadow-reload logic is synthesised.

Decomposition:
- Shared package holds:
  - the state localparams/typedef (IDLE/RUN/HOLD/DONE, 2 bits);
  - the STATE_W=2 constant;
  - the default WIDTH constant.
- Sub-module: countdown_fsm (next-state and output decode), instantiated beside the counter datapath.
- The datapath (counter plus shadow register) stays in countdown_reg.

Test Plan:
- Reset, then load=1, load_value=5, then start=1: cd_data_output reads 5,4,3,2,1,0 on consecutive edges; done=1 after edge 5; ack=1 returns to IDLE with done=0.
- Load 6, start; pause=1 for 3 cycles when value=3: value holds at 3 with state=HOLD, busy=1; after release, 2,1,0 then done.
- Load 0, start: DONE on the next edge, done=1, busy never asserted.
- load=1 (value 9) and start=1 in the same cycle: value=9, state stays IDLE; start on a later cycle counts from 9.
- Load 4, start; reset=1 when value=2: next edge gives cd_data_output=0, IDLE, busy=0, done=0.
- Load 7, start, stop=1 at value 4 together with pause=1: IDLE with value 4 retained (stop beats pause).
- With COUNTDOWN_AUTO_RELOAD_EN, load 3, start: sequence 3,2,1,3,2,1…, done pulses one cycle every 3 cycles.

Source files
------------

// File: rtl/countdown_reg_pkg.sv
// ----------------------------------------------------------------------------
// countdown_reg_pkg
//
// Shared definitions for the loadable down-counter register.
//   - state_e       : FSM state encoding (IDLE/RUN/HOLD/DONE, 2 bits)
//   - STATE_W       : width of the state encoding
//   - DEFAULT_WIDTH : default counter width used by countdown_reg
// ----------------------------------------------------------------------------
package countdown_reg_pkg;

  localparam int STATE_W       = 2;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/countdown_fsm.sv
// ----------------------------------------------------------------------------
// countdown_fsm
//
// Control FSM for countdown_reg. Holds the state register, computes the next
// state from the handshake inputs and the counter status flags, and tells the
// datapath whether to load, decrement or (optionally) reload this edge.
//
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN
//   When defined, the RUN edge that would reach zero reloads the shadow value
//   instead, stays in RUN and pulses done for one cycle.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset
//   load        in   load request (IDLE only)
//   start       in   start request (IDLE only)
//   pause       in   freeze count while RUN/HOLD
//   stop        in   abort count, back to IDLE
//   ack         in   consumer acknowledge of done
//   count_zero  in   counter currently holds zero
//   count_one   in   counter currently holds one (next decrement reaches zero)
//   shadow_zero in   shadow register holds zero (auto-reload build only)
//   do_reload   out  datapath copies shadow into counter (auto-reload only)
//   state_q     out  registered state
//   do_load     out  datapath captures load_value
//   do_dec      out  datapath decrements the counter
//   busy        out  state is RUN or HOLD
//   done        out  state is DONE (or reload pulse in auto-reload build)
// ----------------------------------------------------------------------------
module countdown_fsm
  import countdown_reg_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   start,
  input  logic   pause,
  input  logic   stop,
  input  logic   ack,
  input  logic   count_zero,
  input  logic   count_one,
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  input  logic   shadow_zero,
  output logic   do_reload,
`endif
  output state_e state_q,
  output logic   do_load,
  output logic   do_dec,
  output logic   busy,
  output logic   done
);

  state_e state_d;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic pulse_d;
  logic pulse_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      pulse_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      pulse_q <= pulse_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    do_load = 1'b0;
    do_dec  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    do_reload = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // load beats start when both arrive on the same edge
        if (load) begin
          do_load = 1'b1;
        end else if (start) begin
          state_d = count_zero ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_HOLD;
        end else if (count_one) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          // a zero shadow could never restart, so fall back to DONE
          if (!shadow_zero) begin
            do_reload = 1'b1;
          end else begin
            do_dec  = 1'b1;
            state_d = ST_DONE;
          end
`else
          do_dec  = 1'b1;
          state_d = ST_DONE;
`endif
        end else begin
          do_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // registered so done stays a clean decode of flops, like the DONE state
  always_comb begin
    pulse_d = do_reload;
  end

  assign done = (state_q == ST_DONE) || pulse_q;
`else
  assign done = (state_q == ST_DONE);
`endif

  assign busy = (state_q == ST_RUN) || (state_q == ST_HOLD);

endmodule

// File: rtl/countdown_reg.sv
// ----------------------------------------------------------------------------
// countdown_reg
//
// Loadable down-counter register with a start/done handshake. A value is
// loaded in IDLE, counted down once per cycle in RUN, frozen in HOLD, and
// DONE is held at zero until the consumer acknowledges.
//
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN
//   When defined, a shadow copy of the loaded value is kept and reloaded into
//   the counter each time the count would reach zero, giving a periodic timer
//   with a one-cycle done pulse per period.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   synchronous active-high reset
//   load           in   capture load_value (IDLE only)
//   load_value     in   [WIDTH] value to count down from
//   start          in   begin counting (IDLE only)
//   pause          in   freeze the count while RUN/HOLD
//   stop           in   abort count, return to IDLE keeping the value
//   ack            in   acknowledge done
//   cd_data_output out  [WIDTH] registered counter value
//   busy           out  high in RUN or HOLD
//   done           out  high in DONE
//   state_out      out  [2] current state encoding
// ----------------------------------------------------------------------------
module countdown_reg
  import countdown_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_value,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  input  logic               ack,
  output logic [WIDTH-1:0]   cd_data_output,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] state_out
);

  logic [WIDTH-1:0] cd_d;
  logic [WIDTH-1:0] cd_q;
  logic             count_zero;
  logic             count_one;
  logic             do_load;
  logic             do_dec;
  state_e           state_q;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] shadow_d;
  logic [WIDTH-1:0] shadow_q;
  logic             do_reload;
`endif

  assign count_zero = (cd_q == '0);
  assign count_one  = (cd_q == WIDTH'(1));

  countdown_fsm u_fsm (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .start       (start),
    .pause       (pause),
    .stop        (stop),
    .ack         (ack),
    .count_zero  (count_zero),
    .count_one   (count_one),
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    .shadow_zero (shadow_q == '0),
    .do_reload   (do_reload),
`endif
    .state_q     (state_q),
    .do_load     (do_load),
    .do_dec      (do_dec),
    .busy        (busy),
    .done        (done)
  );

  always_comb begin
    cd_d = cd_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    shadow_d = shadow_q;
`endif
    if (do_load) begin
      cd_d = load_value;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      shadow_d = load_value;
`endif
    end
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    else if (do_reload) begin
      cd_d = shadow_q;
    end
`endif
    else if (do_dec) begin
      // the FSM never requests a decrement at zero, so no underflow guard
      cd_d = cd_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cd_q <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      shadow_q <= '0;
`endif
    end else begin
      cd_q <= cd_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  assign cd_data_output = cd_q;
  assign state_out      = state_q;

endmodule

// File: tb/tb_countdown_reg.sv
// ----------------------------------------------------------------------------
// tb_countdown_reg
//
// Directed bench for countdown_reg. The driver applies one input vector per
// clock and queues the hand-computed response expected after that edge; the
// monitor pops the queue on each falling edge and compares the DUT outputs.
// ----------------------------------------------------------------------------
module tb_countdown_reg;

  localparam int W = 4;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  // control vector bits: {reset, load, start, pause, stop, ack}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] RST  = 6'b100000;
  localparam logic [5:0] LD   = 6'b010000;
  localparam logic [5:0] ST   = 6'b001000;
  localparam logic [5:0] PA   = 6'b000100;
  localparam logic [5:0] SP   = 6'b000010;
  localparam logic [5:0] AK   = 6'b000001;

  typedef struct {
    logic [W-1:0] cd;
    logic [1:0]   st;
    logic         dn;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         load;
  logic [W-1:0] load_value;
  logic         start;
  logic         pause;
  logic         stop;
  logic         ack;
  logic [W-1:0] cd_data_output;
  logic         busy;
  logic         done;
  logic [1:0]   state_out;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors;
  int    checks;

  countdown_reg #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .load           (load),
    .load_value     (load_value),
    .start          (start),
    .pause          (pause),
    .stop           (stop),
    .ack            (ack),
    .cd_data_output (cd_data_output),
    .busy           (busy),
    .done           (done),
    .state_out      (state_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one vector across a rising edge and queue the expected result.
  task automatic applyStimulus(input logic [5:0] ctl, input logic [W-1:0] lv,
                               input logic [W-1:0] e_cd, input logic [1:0] e_st,
                               input logic e_dn, input string nm);
    exp_t e;
    {reset, load, start, pause, stop, ack} = ctl;
    load_value = lv;
    @(posedge clk);
    e.cd = e_cd;
    e.st = e_st;
    e.dn = e_dn;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  task automatic checkOutput(input exp_t e, input string nm);
    logic e_busy;
    e_busy = (e.st == S_RUN) || (e.st == S_HOLD);
    checks++;
    if (cd_data_output !== e.cd) begin
      errors++;
      $display("[TB] FAIL %s.value: got %0d, expected %0d", nm, cd_data_output, e.cd);
    end
    checks++;
    if (state_out !== e.st) begin
      errors++;
      $display("[TB] FAIL %s.state: got %b, expected %b", nm, state_out, e.st);
    end
    checks++;
    if (busy !== e_busy) begin
      errors++;
      $display("[TB] FAIL %s.busy: got %b, expected %b", nm, busy, e_busy);
    end
    checks++;
    if (done !== e.dn) begin
      errors++;
      $display("[TB] FAIL %s.done: got %b, expected %b", nm, done, e.dn);
    end
  endtask

  // Monitor: every falling edge, compare against the oldest queued response.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front(), name_q.pop_front());
    end
  end

  initial begin
    int waited;
    errors = 0;
    checks = 0;
    {reset, load, start, pause, stop, ack} = NONE;
    load_value = '0;

    applyStimulus(RST, 4'd0, 4'd0, S_IDLE, 1'b0, "reset");
    applyStimulus(NONE, 4'd0, 4'd0, S_IDLE, 1'b0, "idle_after_reset");

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // basic count 5 -> 0, done held until ack, load ignored in DONE
    applyStimulus(LD,   4'd5, 4'd5, S_IDLE, 1'b0, "t1_load");
    applyStimulus(ST,   4'd0, 4'd5, S_RUN,  1'b0, "t1_start");
    applyStimulus(NONE, 4'd0, 4'd4, S_RUN,  1'b0, "t1_c4");
    applyStimulus(NONE, 4'd0, 4'd3, S_RUN,  1'b0, "t1_c3");
    applyStimulus(NONE, 4'd0, 4'd2, S_RUN,  1'b0, "t1_c2");
    applyStimulus(NONE, 4'd0, 4'd1, S_RUN,  1'b0, "t1_c1");
    applyStimulus(NONE, 4'd0, 4'd0, S_DONE, 1'b1, "t1_done");
    applyStimulus(NONE, 4'd0, 4'd0, S_DONE, 1'b1, "t1_hold_done");
    applyStimulus(LD,   4'd7, 4'd0, S_DONE, 1'b1, "t1_load_in_done");
    applyStimulus(AK,   4'd0, 4'd0, S_IDLE, 1'b0, "t1_ack");

    // pause at 3 for three cycles
    applyStimulus(LD,   4'd6, 4'd6, S_IDLE, 1'b0, "t2_load");
    applyStimulus(ST,   4'd0, 4'd6, S_RUN,  1'b0, "t2_start");
    applyStimulus(NONE, 4'd0, 4'd5, S_RUN,  1'b0, "t2_c5");
    applyStimulus(NONE, 4'd0, 4'd4, S_RUN,  1'b0, "t2_c4");
    applyStimulus(NONE, 4'd0, 4'd3, S_RUN,  1'b0, "t2_c3");
    applyStimulus(PA,   4'd0, 4'd3, S_HOLD, 1'b0, "t2_pause1");
    applyStimulus(PA,   4'd0, 4'd3, S_HOLD, 1'b0, "t2_pause2");
    applyStimulus(PA,   4'd0, 4'd3, S_HOLD, 1'b0, "t2_pause3");
    applyStimulus(NONE, 4'd0, 4'd3, S_RUN,  1'b0, "t2_resume");
    applyStimulus(NONE, 4'd0, 4'd2, S_RUN,  1'b0, "t2_c2");
    applyStimulus(NONE, 4'd0, 4'd1, S_RUN,  1'b0, "t2_c1");
    applyStimulus(NONE, 4'd0, 4'd0, S_DONE, 1'b1, "t2_done");
    applyStimulus(AK,   4'd0, 4'd0, S_IDLE, 1'b0, "t2_ack");

    // zero load goes straight to DONE
    applyStimulus(LD,   4'd0, 4'd0, S_IDLE, 1'b0, "t3_load0");
    applyStimulus(ST,   4'd0, 4'd0, S_DONE, 1'b1, "t3_start0");
    applyStimulus(AK,   4'd0, 4'd0, S_IDLE, 1'b0, "t3_ack");

    // load beats start; stray inputs in IDLE/RUN ignored
    applyStimulus(LD|ST,    4'd9, 4'd9, S_IDLE, 1'b0, "t4_load_start");
    applyStimulus(NONE,     4'd0, 4'd9, S_IDLE, 1'b0, "t4_idle");
    applyStimulus(PA|SP|AK, 4'd0, 4'd9, S_IDLE, 1'b0, "t4_idle_noise");
    applyStimulus(ST,       4'd0, 4'd9, S_RUN,  1'b0, "t4_start");
    applyStimulus(NONE,     4'd0, 4'd8, S_RUN,  1'b0, "t4_c8");
    applyStimulus(LD|ST,    4'd2, 4'd7, S_RUN,  1'b0, "t4_load_in_run");
    applyStimulus(SP,       4'd0, 4'd7, S_IDLE, 1'b0, "t4_stop");

    // reset mid-count
    applyStimulus(LD,   4'd4, 4'd4, S_IDLE, 1'b0, "t5_load");
    applyStimulus(ST,   4'd0, 4'd4, S_RUN,  1'b0, "t5_start");
    applyStimulus(NONE, 4'd0, 4'd3, S_RUN,  1'b0, "t5_c3");
    applyStimulus(NONE, 4'd0, 4'd2, S_RUN,  1'b0, "t5_c2");
    applyStimulus(RST|PA, 4'd0, 4'd0, S_IDLE, 1'b0, "t5_reset");

    // stop beats pause, in RUN and in HOLD
    applyStimulus(LD,    4'd7, 4'd7, S_IDLE, 1'b0, "t6_load");
    applyStimulus(ST,    4'd0, 4'd7, S_RUN,  1'b0, "t6_start");
    applyStimulus(NONE,  4'd0, 4'd6, S_RUN,  1'b0, "t6_c6");
    applyStimulus(NONE,  4'd0, 4'd5, S_RUN,  1'b0, "t6_c5");
    applyStimulus(NONE,  4'd0, 4'd4, S_RUN,  1'b0, "t6_c4");
    applyStimulus(SP|PA, 4'd0, 4'd4, S_IDLE, 1'b0, "t6_stop_pause");
    applyStimulus(ST,    4'd0, 4'd4, S_RUN,  1'b0, "t6_restart");
    applyStimulus(NONE,  4'd0, 4'd3, S_RUN,  1'b0, "t6_c3");
    applyStimulus(PA,    4'd0, 4'd3, S_HOLD, 1'b0, "t6_pause");
    applyStimulus(SP|PA, 4'd0, 4'd3, S_IDLE, 1'b0, "t6_stop_hold");

    // full-scale value
    applyStimulus(LD,   4'd15, 4'd15, S_IDLE, 1'b0, "t7_load15");
    applyStimulus(ST,   4'd0,  4'd15, S_RUN,  1'b0, "t7_start");
    applyStimulus(NONE, 4'd0,  4'd14, S_RUN,  1'b0, "t7_c14");
    applyStimulus(SP,   4'd0,  4'd14, S_IDLE, 1'b0, "t7_stop");
`else
    // auto-reload: 3,2,1,3,2,1 with a one-cycle done pulse on each reload
    applyStimulus(LD,   4'd3, 4'd3, S_IDLE, 1'b0, "a1_load");
    applyStimulus(ST,   4'd0, 4'd3, S_RUN,  1'b0, "a1_start");
    applyStimulus(NONE, 4'd0, 4'd2, S_RUN,  1'b0, "a1_c2");
    applyStimulus(NONE, 4'd0, 4'd1, S_RUN,  1'b0, "a1_c1");
    applyStimulus(NONE, 4'd0, 4'd3, S_RUN,  1'b1, "a1_reload1");
    applyStimulus(NONE, 4'd0, 4'd2, S_RUN,  1'b0, "a1_c2b");
    applyStimulus(NONE, 4'd0, 4'd1, S_RUN,  1'b0, "a1_c1b");
    applyStimulus(NONE, 4'd0, 4'd3, S_RUN,  1'b1, "a1_reload2");
    applyStimulus(AK,   4'd0, 4'd2, S_RUN,  1'b0, "a1_ack_ignored");
    applyStimulus(PA,   4'd0, 4'd2, S_HOLD, 1'b0, "a1_pause");
    applyStimulus(NONE, 4'd0, 4'd2, S_RUN,  1'b0, "a1_resume");
    applyStimulus(NONE, 4'd0, 4'd1, S_RUN,  1'b0, "a1_c1c");
    applyStimulus(SP,   4'd0, 4'd1, S_IDLE, 1'b0, "a1_stop");
    applyStimulus(LD,   4'd0, 4'd0, S_IDLE, 1'b0, "a2_load0");
    applyStimulus(ST,   4'd0, 4'd0, S_DONE, 1'b1, "a2_start0");
    applyStimulus(NONE, 4'd0, 4'd0, S_DONE, 1'b1, "a2_hold_done");
    applyStimulus(AK,   4'd0, 4'd0, S_IDLE, 1'b0, "a2_ack");
`endif

    {reset, load, start, pause, stop, ack} = NONE;
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d responses left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
